theta_func: RTL

- Streaming column-parity mixing stage for a 1600-bit state held as 64 slices of 25 bits; the slice index is z = 0..63.
- Sits directly upstream of the permutation stage and feeds it one 25-bit slice per transfer.
- Collects all 64 slices first, because slice z needs the parities of slice z-1 (mod 64).
- Then emits 64 mixed slices in z order.
- Slice bit index i = 5*y + x, with x, y in 0..4.

---
 rtl/theta_func.sv | 115 +++++++++++
 1 files changed

// File: rtl/theta_func.sv
// Streaming column-parity mixing stage: buffers a 64-slice state with per-slice
// column parities, then emits each slice mixed with neighbouring-column parities.
module theta_func #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [24:0] in_slice,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [24:0] out_slice,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiet
  // LOAD  | accepting slices into the buffers, cnt = next write index
  // EMIT  | presenting mixed slice cnt until downstream takes it
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_prev;
  logic [24:0]      slice_mem [DEPTH];
  logic [4:0]       par_mem   [DEPTH];
  logic [4:0]       in_par;
  logic [4:0]       c_cur;
  logic [4:0]       c_prev;
  logic [4:0]       d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Buffers are deliberately unreset; they are fully rewritten before every EMIT.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      slice_mem[cnt] <= in_slice;
      par_mem[cnt]   <= in_par;
    end
  end

  for (genvar x = 0; x < 5; x++) begin : g_col
    assign in_par[x] = in_slice[x] ^ in_slice[x+5] ^ in_slice[x+10]
                     ^ in_slice[x+15] ^ in_slice[x+20];
    assign d[x] = c_cur[(x+4)%5] ^ c_prev[(x+1)%5];
  end

  // Slice 0 mixes with the parity of slice DEPTH-1.
  assign cnt_prev = (cnt == '0) ? LAST : cnt - 1'b1;
  assign c_cur    = par_mem[cnt];
  assign c_prev   = par_mem[cnt_prev];
  assign out_slice = out_valid ? (slice_mem[cnt] ^ {5{d}}) : '0;

endmodule
